// File: rtl/datapath_if.sv
// Control/memory-side bundle for the single-bus datapath: bus-drive strobes,
// load enables, ALU controls, memory read data and the observable outputs.
interface datapath_if #(
    parameter int unsigned WIDTH = 32
);
    logic             PCout;
    logic             ZHighout;
    logic             ZLowout;
    logic             HIout;
    logic             LOout;
    logic             InPortout;
    logic             Cout;
    logic             MDRout;
    logic             R2out;
    logic             R4out;

    logic             MARin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             HIin;
    logic             LOin;
    logic             Cin;
    logic             R2in;
    logic             R4in;
    logic             R5in;
    logic             ZHIin;
    logic             ZLOin;

    logic             Read;
    logic             IncPC;
    logic [4:0]       operation;
    logic [WIDTH-1:0] Mdatain;
    logic             branch_flag;

    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] o_mar;
    logic [WIDTH-1:0] o_ir;

    modport master (
        output PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout,
               R2out, R4out,
        output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Cin, R2in, R4in, R5in,
               ZHIin, ZLOin,
        output Read, IncPC, operation, Mdatain, branch_flag,
        input  BusMuxOut, o_mar, o_ir
    );

    modport slave (
        input  PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout,
               R2out, R4out,
        input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Cin, R2in, R4in, R5in,
               ZHIin, ZLOin,
        input  Read, IncPC, operation, Mdatain, branch_flag,
        output BusMuxOut, o_mar, o_ir
    );
endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: bus mux, register subset, 64-bit Z and a
// zero-latency ALU fed by Y (A) and the bus (B).
module datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      clr,
    datapath_if.slave dp
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned ZW  = 2 * WIDTH;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_r4;
    logic [WIDTH-1:0] r_r5;
    logic [ZW-1:0]    r_z;

    logic [WIDTH-1:0] w_bus;
    logic [WIDTH-1:0] w_inport;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [SHW-1:0]   w_sh;
    logic [ZW-1:0]    w_dbl;
    logic [ZW-1:0]    w_rot_r;
    logic [ZW-1:0]    w_rot_l;
    logic [ZW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    // InPort has no load path in this block, so it reads as zero.
    assign w_inport = '0;

    // Bus mux, fixed priority; idle bus reads zero.
    always_comb begin
        w_bus = '0;
        if (dp.ZHighout)       w_bus = r_z[ZW-1:WIDTH];
        else if (dp.ZLowout)   w_bus = r_z[WIDTH-1:0];
        else if (dp.PCout)     w_bus = r_pc;
        else if (dp.MDRout)    w_bus = r_mdr;
        else if (dp.HIout)     w_bus = r_hi;
        else if (dp.LOout)     w_bus = r_lo;
        else if (dp.InPortout) w_bus = w_inport;
        else if (dp.Cout)      w_bus = r_c;
        else if (dp.R2out)     w_bus = r_r2;
        else if (dp.R4out)     w_bus = r_r4;
    end

    assign dp.BusMuxOut = w_bus;
    assign dp.o_mar     = r_mar;
    assign dp.o_ir      = r_ir;

    // Rotates take the appropriate half of the doubled operand.
    assign w_sh    = w_bus[SHW-1:0];
    assign w_dbl   = {r_y, r_y};
    assign w_rot_r = w_dbl >> w_sh;
    assign w_rot_l = w_dbl << w_sh;
    // Sign-extended operands give the signed product in the low 2*WIDTH bits.
    assign w_prod  = {{WIDTH{r_y[WIDTH-1]}}, r_y} * {{WIDTH{w_bus[WIDTH-1]}}, w_bus};

    always_comb begin
        w_quot = '0;
        w_rem  = '0;
        if (w_bus != '0) begin
            w_quot = WIDTH'($signed(r_y) / $signed(w_bus));
            w_rem  = WIDTH'($signed(r_y) % $signed(w_bus));
        end
    end

    // ALU: IncPC overrides the opcode; unknown opcodes yield zero.
    always_comb begin
        w_res_lo = '0;
        w_res_hi = '0;
        if (dp.IncPC) begin
            w_res_lo = w_bus + WIDTH'(1);
        end else begin
            case (dp.operation)
                OP_ADD: w_res_lo = r_y + w_bus;
                OP_SUB: w_res_lo = r_y - w_bus;
                OP_SHR: w_res_lo = r_y >> w_sh;
                OP_SHL: w_res_lo = r_y << w_sh;
                OP_ROR: w_res_lo = w_rot_r[WIDTH-1:0];
                OP_ROL: w_res_lo = w_rot_l[ZW-1:WIDTH];
                OP_AND: w_res_lo = r_y & w_bus;
                OP_OR:  w_res_lo = r_y | w_bus;
                OP_NEG: w_res_lo = '0 - w_bus;
                OP_NOT: w_res_lo = ~w_bus;
                OP_MUL: begin
                    w_res_lo = w_prod[WIDTH-1:0];
                    w_res_hi = w_prod[ZW-1:WIDTH];
                end
                OP_DIV: begin
                    w_res_lo = w_quot;
                    w_res_hi = w_rem;
                end
                default: begin
                    w_res_lo = '0;
                    w_res_hi = '0;
                end
            endcase
        end
    end

    // Register file and special registers; each holds unless its enable is set.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_c   <= '0;
            r_r2  <= '0;
            r_r4  <= '0;
            r_r5  <= '0;
            r_z   <= '0;
        end else begin
            if (dp.PCin || dp.branch_flag) r_pc <= w_bus;
            if (dp.IRin)  r_ir  <= w_bus;
            if (dp.MARin) r_mar <= w_bus;
            if (dp.MDRin) r_mdr <= dp.Read ? dp.Mdatain : w_bus;
            if (dp.Yin)   r_y   <= w_bus;
            if (dp.HIin)  r_hi  <= w_bus;
            if (dp.LOin)  r_lo  <= w_bus;
            if (dp.Cin)   r_c   <= w_bus;
            if (dp.R2in)  r_r2  <= w_bus;
            if (dp.R4in)  r_r4  <= w_bus;
            if (dp.R5in)  r_r5  <= w_bus;
            if (dp.ZLOin) r_z[WIDTH-1:0]  <= w_res_lo;
            if (dp.ZHIin) r_z[ZW-1:WIDTH] <= w_res_hi;
        end
    end

    // R5 has no bus-drive strobe; keep it visible for lint as a load-only sink.
    logic w_r5_unused;
    assign w_r5_unused = ^r_r5;
endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the single-bus datapath with hand-computed results.
module tb_datapath;
    logic clk;
    logic clr;
    int   n_vec;
    int   n_err;

    datapath_if #(.WIDTH(32)) dp_if ();

    datapath #(.WIDTH(32)) u_dut (
        .clk (clk),
        .clr (clr),
        .dp  (dp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dp_if.PCout = 0; dp_if.ZHighout = 0; dp_if.ZLowout = 0; dp_if.HIout = 0;
        dp_if.LOout = 0; dp_if.InPortout = 0; dp_if.Cout = 0; dp_if.MDRout = 0;
        dp_if.R2out = 0; dp_if.R4out = 0;
        dp_if.MARin = 0; dp_if.PCin = 0; dp_if.MDRin = 0; dp_if.IRin = 0;
        dp_if.Yin = 0; dp_if.HIin = 0; dp_if.LOin = 0; dp_if.Cin = 0;
        dp_if.R2in = 0; dp_if.R4in = 0; dp_if.R5in = 0; dp_if.ZHIin = 0; dp_if.ZLOin = 0;
        dp_if.Read = 0; dp_if.IncPC = 0; dp_if.operation = 5'd0; dp_if.branch_flag = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        dp_if.Mdatain = v; dp_if.Read = 1; dp_if.MDRin = 1;
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        mdr_load(v);
        dp_if.MDRout = 1; dp_if.Yin = 1;
        tick();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
        mdr_load(b);
        dp_if.MDRout = 1; dp_if.operation = op; dp_if.ZLOin = 1; dp_if.ZHIin = 1;
        tick();
    endtask

    task automatic read_z(output logic [63:0] z);
        dp_if.ZHighout = 1; #1 z[63:32] = dp_if.BusMuxOut; dp_if.ZHighout = 0;
        dp_if.ZLowout = 1;  #1 z[31:0]  = dp_if.BusMuxOut; dp_if.ZLowout = 0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] exp;
        string       tag;
    } sweep_t;

    sweep_t sweep [11];
    logic [63:0] z;

    initial begin
        n_vec = 0;
        n_err = 0;
        dp_if.Mdatain = '0;
        idle();
        sweep[0]  = '{5'b00011, 32'h8000_0002, "add"};
        sweep[1]  = '{5'b00100, 32'h8000_0000, "sub"};
        sweep[2]  = '{5'b00101, 32'h4000_0000, "shr"};
        sweep[3]  = '{5'b00110, 32'h0000_0002, "shl"};
        sweep[4]  = '{5'b00111, 32'hC000_0000, "ror"};
        sweep[5]  = '{5'b01000, 32'h0000_0003, "rol"};
        sweep[6]  = '{5'b01001, 32'h0000_0001, "and"};
        sweep[7]  = '{5'b01010, 32'h8000_0001, "or"};
        sweep[8]  = '{5'b10000, 32'hFFFF_FFFF, "neg"};
        sweep[9]  = '{5'b10001, 32'hFFFF_FFFE, "not"};
        sweep[10] = '{5'b11111, 32'h0000_0000, "badop"};

        clr = 0;
        #12;
        check_vec("rst_bus", {32'h0, dp_if.BusMuxOut}, 64'h0);
        check_vec("rst_mar", {32'h0, dp_if.o_mar}, 64'h0);
        @(negedge clk) clr = 1;
        @(posedge clk); #1;

        // Register loads through MDR
        mdr_load(32'h22);
        dp_if.MDRout = 1; dp_if.R2in = 1;
        #1 check_vec("bus_mdr", {32'h0, dp_if.BusMuxOut}, 64'h22);
        tick();
        dp_if.R2out = 1;
        #1 check_vec("r2", {32'h0, dp_if.BusMuxOut}, 64'h22);
        idle();
        mdr_load(32'h11);
        dp_if.MDRout = 1; dp_if.R4in = 1; tick();
        dp_if.R4out = 1;
        #1 check_vec("r4", {32'h0, dp_if.BusMuxOut}, 64'h11);
        idle();
        mdr_load(32'h26);
        dp_if.MDRout = 1; dp_if.R5in = 1; tick();

        // Fetch
        dp_if.PCout = 1; dp_if.MARin = 1; dp_if.IncPC = 1; dp_if.ZLOin = 1;
        tick();
        check_vec("fetch_mar", {32'h0, dp_if.o_mar}, 64'h0);
        dp_if.ZLowout = 1; dp_if.PCin = 1;
        dp_if.Mdatain = 32'h4A92_0000; dp_if.Read = 1; dp_if.MDRin = 1;
        #1 check_vec("fetch_zlo", {32'h0, dp_if.BusMuxOut}, 64'h1);
        tick();
        dp_if.PCout = 1;
        #1 check_vec("fetch_pc", {32'h0, dp_if.BusMuxOut}, 64'h1);
        idle();
        dp_if.MDRout = 1; dp_if.IRin = 1; tick();
        check_vec("fetch_ir", {32'h0, dp_if.o_ir}, 64'h4A92_0000);

        // Divide 0x22 / 0x11
        dp_if.R2out = 1; dp_if.Yin = 1; tick();
        dp_if.R4out = 1; dp_if.operation = 5'b01111; dp_if.ZLOin = 1; dp_if.ZHIin = 1;
        tick();
        read_z(z);
        check_vec("div_z", z, 64'h0000_0000_0000_0002);
        dp_if.ZLowout = 1; dp_if.R5in = 1; dp_if.LOin = 1; tick();
        dp_if.LOout = 1;
        #1 check_vec("div_lo", {32'h0, dp_if.BusMuxOut}, 64'h2);
        idle();

        // Signed divide with remainder, and divide by zero
        set_y(32'hFFFF_FFF9);
        alu_op(5'b01111, 32'h2);
        read_z(z);
        check_vec("div_neg", z, 64'hFFFF_FFFF_FFFF_FFFD);
        alu_op(5'b01111, 32'h0);
        read_z(z);
        check_vec("div_zero", z, 64'h0);

        // Multiply, then move Z halves to HI/LO
        set_y(32'hFFFF_FFFE);
        alu_op(5'b01110, 32'h3);
        read_z(z);
        check_vec("mul_z", z, 64'hFFFF_FFFF_FFFF_FFFA);
        dp_if.ZHighout = 1; dp_if.HIin = 1; tick();
        dp_if.ZLowout = 1; dp_if.LOin = 1; tick();
        dp_if.HIout = 1;
        #1 check_vec("mul_hi", {32'h0, dp_if.BusMuxOut}, 64'hFFFF_FFFF);
        idle();
        dp_if.LOout = 1;
        #1 check_vec("mul_lo", {32'h0, dp_if.BusMuxOut}, 64'hFFFF_FFFA);
        idle();

        // Z halves load independently: only low half written here
        mdr_load(32'h5);
        dp_if.MDRout = 1; dp_if.operation = 5'b00011; dp_if.ZLOin = 1; tick();
        read_z(z);
        check_vec("zlo_only", z, 64'hFFFF_FFFF_0000_0003);

        // Z read and reloaded in the same cycle captures pre-edge value + 1
        dp_if.ZLowout = 1; dp_if.IncPC = 1; dp_if.ZLOin = 1; tick();
        read_z(z);
        check_vec("z_rmw", z, 64'hFFFF_FFFF_0000_0004);

        // Bus priority: ZLowout beats PCout and MDRout
        dp_if.ZLowout = 1; dp_if.PCout = 1; dp_if.MDRout = 1;
        #1 check_vec("prio", {32'h0, dp_if.BusMuxOut}, 64'h4);
        idle();

        // ALU sweep with Y=0x80000001, B=1
        set_y(32'h8000_0001);
        foreach (sweep[i]) begin
            alu_op(sweep[i].op, 32'h1);
            read_z(z);
            check_vec(sweep[i].tag, z, {32'h0, sweep[i].exp});
        end

        // C register, InPort reads zero
        mdr_load(32'hC0DE_0001);
        dp_if.MDRout = 1; dp_if.Cin = 1; tick();
        dp_if.Cout = 1;
        #1 check_vec("c_reg", {32'h0, dp_if.BusMuxOut}, 64'hC0DE_0001);
        idle();
        dp_if.InPortout = 1;
        #1 check_vec("inport", {32'h0, dp_if.BusMuxOut}, 64'h0);
        idle();

        // Branch loads PC from bus
        mdr_load(32'h40);
        dp_if.MDRout = 1; dp_if.branch_flag = 1; tick();
        dp_if.PCout = 1;
        #1 check_vec("branch_pc", {32'h0, dp_if.BusMuxOut}, 64'h40);
        idle();

        // Asynchronous reset between clock edges
        #2 clr = 0;
        #1;
        dp_if.PCout = 1;  #1 check_vec("clr_pc",  {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.MDRout = 1; #1 check_vec("clr_mdr", {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.HIout = 1;  #1 check_vec("clr_hi",  {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.LOout = 1;  #1 check_vec("clr_lo",  {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.Cout = 1;   #1 check_vec("clr_c",   {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.R2out = 1;  #1 check_vec("clr_r2",  {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        dp_if.R4out = 1;  #1 check_vec("clr_r4",  {32'h0, dp_if.BusMuxOut}, 64'h0); idle();
        read_z(z);
        check_vec("clr_z", z, 64'h0);
        check_vec("clr_ir", {32'h0, dp_if.o_ir}, 64'h0);
        @(negedge clk) clr = 1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
